// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// RV32I load/store width codes and small decode helpers.
package dmem_pkg;

    // Transaction sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Load width/sign codes.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store width codes.
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // True when funct3 names a real access for the given direction.
    // Stores have no unsigned forms, so 1xx is undefined for them.
    function automatic logic f3_defined(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // Halfword access (LH, LHU, SH).
    function automatic logic is_half(input logic [2:0] f3);
        return (f3[1:0] == 2'b01);
    endfunction

    // Word access (LW, SW).
    function automatic logic is_word(input logic [2:0] f3);
        return (f3 == F3_LW);
    endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// Load lane selection and sign/zero extension. Purely combinational.
// Halfwords are taken from addr_lo[1] only, words from lane 0, so a
// misaligned access quietly reads the naturally aligned container.
module dmem_load_extend
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  lane_bytes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_bytes[gi] = word[8*gi +: 8];
        end
    endgenerate

    // Pick the addressed lane and extend it to 32 bits.
    always_comb begin
        byte_sel = lane_bytes[addr_lo];
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data = {24'h0, byte_sel};
            F3_LHU:  data = {16'h0, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-port data memory answering RV32I loads/stores with a fixed
// number of wait states. Request handshake in IDLE, optional WAIT
// countdown, response held in RESP until taken.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to fault misaligned
// halfword/word accesses instead of forcing natural alignment.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
)(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        err_q, err_d;

    logic        enter_resp;
    logic        acc_err;
    logic [3:0]  byte_en;
    logic [31:0] wlane;
    logic [IDX_W-1:0] word_idx;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_word_q;
    logic [31:0] ext_data;

    // Next-state, counter and request-latch logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    funct3_d = req_funct3;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The access happens on the edge that enters RESP. With zero wait
    // states that is the accepting edge, so the access uses the _d view
    // of the request rather than the latched copy.
    always_comb begin
        enter_resp = (state_q != RESP) && (state_d == RESP);
        acc_err    = !f3_defined(we_d, funct3_d) ||
                     ({2'b00, addr_d[31:2]} >= 32'(DEPTH_WORDS));
`ifdef DMEM_MISALIGN_TRAP_EN
        if (is_half(funct3_d) && addr_d[0]) begin
            acc_err = 1'b1;
        end
        if (is_word(funct3_d) && (addr_d[1:0] != 2'b00)) begin
            acc_err = 1'b1;
        end
`endif
        err_d    = enter_resp ? acc_err : err_q;
        word_idx = addr_d[IDX_W+1:2];
    end

    // Byte-lane enables and replicated store data; alignment is forced
    // by only looking at the address bits that matter for each width.
    always_comb begin
        case (funct3_d[1:0])
            2'b00: begin
                byte_en = 4'b0001 << addr_d[1:0];
                wlane   = {4{wdata_d[7:0]}};
            end
            2'b01: begin
                byte_en = addr_d[1] ? 4'b1100 : 4'b0011;
                wlane   = {2{wdata_d[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wlane   = wdata_d;
            end
        endcase
    end

    // Control state with asynchronous reset; storage is never reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            funct3_q <= 3'b000;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            err_q    <= err_d;
        end
    end

    // Memory array: byte-lane write or registered read on RESP entry.
    always_ff @(posedge clock) begin
        if (enter_resp && !acc_err) begin
            if (we_d) begin
                for (int b = 0; b < 4; b++) begin
                    if (byte_en[b]) begin
                        mem[word_idx][8*b +: 8] <= wlane[8*b +: 8];
                    end
                end
            end else begin
                rd_word_q <= mem[word_idx];
            end
        end
    end

    dmem_load_extend u_load_extend (
        .word    (rd_word_q),
        .addr_lo (addr_q[1:0]),
        .funct3  (funct3_q),
        .data    (ext_data)
    );

    // Outputs decode from state so reset clears them immediately.
    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        rsp_err   = (state_q == RESP) && err_q;
        rsp_rdata = ((state_q == RESP) && !err_q && !we_q) ? ext_data : 32'h0;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states
// and one with none, each driven from its own request/response signals.
module tb_dmem_responder;

    logic        clock = 1'b0;
    logic        reset;

    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [2:0]  req_funct3;

    logic        req_valid0, req_ready0, req_we0, rsp_valid0, rsp_ready0, rsp_err0;
    logic [31:0] req_addr0, req_wdata0, rsp_rdata0;
    logic [2:0]  req_funct30;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;

    always #5 clock = ~clock;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u_dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut0 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .req_funct3(req_funct30),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    // One full transaction on the two-wait-state instance. lat counts
    // edges from the accepting edge (=1) until rsp_valid is seen high.
    task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, output logic [31:0] rdo,
                        output logic ero, output int lato);
        @(negedge clock);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3;
        rsp_ready = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b0;
        lato = 1;
        while (!rsp_valid && lato < 40) begin
            @(posedge clock); #1;
            lato++;
        end
        rdo = rsp_rdata;
        ero = rsp_err;
        @(negedge clock); rsp_ready = 1'b1;
        @(posedge clock); #1; rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_funct3 = 0; rsp_ready = 0;
        req_valid0 = 0; req_we0 = 0; req_addr0 = 0; req_wdata0 = 0; req_funct30 = 0; rsp_ready0 = 0;
        #1;
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'h0);
        chk("rst rsp_err", 32'(rsp_err), 32'd0);
        chk("rst0 req_ready", 32'(req_ready0), 32'd1);
        repeat (2) @(posedge clock);
        @(negedge clock); reset = 1'b0;

        // Word store then word load with latency check.
        xact(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, er, lat);
        chk("sw rdata", rd, 32'h0);
        chk("sw err", 32'(er), 32'd0);
        chk("sw lat", 32'(lat), 32'd3);
        xact(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
        chk("lw rdata", rd, 32'hDEADBEEF);
        chk("lw err", 32'(er), 32'd0);
        chk("lw lat", 32'(lat), 32'd3);

        // Sub-word loads with extension.
        xact(1'b0, 32'h13, 32'h0, 3'b000, rd, er, lat);
        chk("lb 13", rd, 32'hFFFFFFDE);
        xact(1'b0, 32'h13, 32'h0, 3'b100, rd, er, lat);
        chk("lbu 13", rd, 32'h000000DE);
        xact(1'b0, 32'h10, 32'h0, 3'b101, rd, er, lat);
        chk("lhu 10", rd, 32'h0000BEEF);

        // Byte store into lane 1.
        xact(1'b1, 32'h11, 32'h00000012, 3'b000, rd, er, lat);
        xact(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
        chk("lw after sb", rd, 32'hDEAD12EF);
        xact(1'b0, 32'h12, 32'h0, 3'b001, rd, er, lat);
        chk("lh 12", rd, 32'hFFFFDEAD);
        xact(1'b0, 32'h10, 32'h0, 3'b000, rd, er, lat);
        chk("lb 10", rd, 32'hFFFFFFEF);

        // Halfword store into the upper half.
        xact(1'b1, 32'h14, 32'h0, 3'b010, rd, er, lat);
        xact(1'b1, 32'h16, 32'h00007A55, 3'b001, rd, er, lat);
        xact(1'b0, 32'h14, 32'h0, 3'b010, rd, er, lat);
        chk("lw after sh", rd, 32'h7A550000);

        // Out-of-range accesses fault and do not alias onto word 0.
        xact(1'b0, 32'h400, 32'h0, 3'b010, rd, er, lat);
        chk("oor lw err", 32'(er), 32'd1);
        chk("oor lw rdata", rd, 32'h0);
        xact(1'b1, 32'h0, 32'h11111111, 3'b010, rd, er, lat);
        xact(1'b1, 32'h400, 32'h22222222, 3'b010, rd, er, lat);
        chk("oor sw err", 32'(er), 32'd1);
        xact(1'b0, 32'h0, 32'h0, 3'b010, rd, er, lat);
        chk("word0 intact", rd, 32'h11111111);

        // Undefined funct3 codes.
        xact(1'b0, 32'h10, 32'h0, 3'b011, rd, er, lat);
        chk("bad f3 ld err", 32'(er), 32'd1);
        chk("bad f3 ld data", rd, 32'h0);
        xact(1'b1, 32'h10, 32'hFFFFFFFF, 3'b100, rd, er, lat);
        chk("bad f3 st err", 32'(er), 32'd1);
        xact(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
        chk("no bad write", rd, 32'hDEAD12EF);

        // Response held under back-pressure while a new request waits.
        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; rsp_ready = 1'b0;
        @(posedge clock); #1;
        req_addr = 32'h0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        chk("hold lat", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            chk("hold valid", 32'(rsp_valid), 32'd1);
            chk("hold rdata", rsp_rdata, 32'hDEAD12EF);
            chk("hold ready", 32'(req_ready), 32'd0);
        end
        @(negedge clock); rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        chk("release idle", 32'(req_ready), 32'd1);
        chk("release valid", 32'(rsp_valid), 32'd0);
        @(negedge clock); req_valid = 1'b0;

        // Reset during WAIT drops the store.
        xact(1'b1, 32'h20, 32'hCAFEF00D, 3'b010, rd, er, lat);
        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h1; req_funct3 = 3'b010;
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("in wait", 32'(req_ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("mid rst valid", 32'(rsp_valid), 32'd0);
        chk("mid rst ready", 32'(req_ready), 32'd1);
        chk("mid rst rdata", rsp_rdata, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        chk("rst hold valid", 32'(rsp_valid), 32'd0);
        @(negedge clock); reset = 1'b0;
        xact(1'b0, 32'h20, 32'h0, 3'b010, rd, er, lat);
        chk("store dropped", rd, 32'hCAFEF00D);
        chk("after rst err", 32'(er), 32'd0);
        xact(1'b0, 32'h21, 32'h0, 3'b001, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("lh 21 err", 32'(er), 32'd1);
        chk("lh 21 data", rd, 32'h0);
`else
        chk("lh 21 err", 32'(er), 32'd0);
        chk("lh 21 data", rd, 32'hFFFFF00D);
`endif

        // Zero-wait-state instance: response right after the accept edge.
        @(negedge clock);
        req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 32'h8; req_wdata0 = 32'h000055AA;
        req_funct30 = 3'b010; rsp_ready0 = 1'b0;
        chk("w0 pre valid", 32'(rsp_valid0), 32'd0);
        @(posedge clock); #1;
        req_valid0 = 1'b0;
        chk("w0 sw valid", 32'(rsp_valid0), 32'd1);
        chk("w0 sw err", 32'(rsp_err0), 32'd0);
        @(negedge clock); rsp_ready0 = 1'b1;
        @(posedge clock); #1; rsp_ready0 = 1'b0;
        @(negedge clock);
        req_valid0 = 1'b1; req_we0 = 1'b0; req_addr0 = 32'h9; req_funct30 = 3'b100;
        @(posedge clock); #1;
        req_valid0 = 1'b0;
        chk("w0 lbu valid", 32'(rsp_valid0), 32'd1);
        chk("w0 lbu data", rsp_rdata0, 32'h00000055);
        @(negedge clock); rsp_ready0 = 1'b1;
        @(posedge clock); #1; rsp_ready0 = 1'b0;
        chk("w0 idle", 32'(req_ready0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
